// File: rtl/func_test_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : func_test_mailbox
// Purpose  : Passive test-result mailbox that snoops bus writes into a 32-byte
//            window and records a PASS/FAIL/TIMEOUT verdict, error fields and a log FIFO.
//            Optional TIMEOUT watchdog: MIST1032ISA_FUNC_MAILBOX_TIMEOUT_EN
// Revision : 1.0  initial release
// ============================================================================
module func_test_mailbox #(
  parameter logic [31:0] P_BASE_ADDR   = 32'h0002_0000,
  parameter int          P_SWAP        = 1,
  parameter int          P_LOG_DEPTH   = 8,
  parameter int          P_LOG_DEPTH_N = 3,
  parameter logic [31:0] P_TIMEOUT     = 32'd750000
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iMEMORY_REQ,
  input  logic        iMEMORY_LOCK,
  input  logic [1:0]  iMEMORY_ORDER,
  input  logic        iMEMORY_RW,
  input  logic [31:0] iMEMORY_ADDR,
  input  logic [31:0] iMEMORY_DATA,
  output logic [1:0]  oSTATE,
  output logic        oDONE,
  output logic [31:0] oERR_TYPE,
  output logic [31:0] oERR_NUM,
  output logic [31:0] oERR_RESULT,
  output logic [31:0] oERR_EXPECT,
  output logic [15:0] oFAIL_CNT,
  output logic        oBAD_ACCESS,
  output logic        oLOG_VALID,
  output logic [31:0] oLOG_DATA,
  input  logic        iLOG_RD,
  output logic        oLOG_OVF
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_t;

  localparam logic [P_LOG_DEPTH_N:0]   C_FULL    = (P_LOG_DEPTH_N+1)'(P_LOG_DEPTH);
  localparam logic [P_LOG_DEPTH_N:0]   C_CNT_ONE = (P_LOG_DEPTH_N+1)'(1);
  localparam logic [P_LOG_DEPTH_N-1:0] C_PTR_ONE = (P_LOG_DEPTH_N)'(1);

  state_t r_state, w_stateNext;
  logic        r_flag;
  logic [31:0] r_errType, r_errNum, r_errResult, r_errExpect;
  logic [15:0] r_failCnt;
  logic        r_badAccess, r_logOvf;
  logic [31:0] r_mem [P_LOG_DEPTH];
  logic [P_LOG_DEPTH_N-1:0] r_wrPtr, r_rdPtr;
  logic [P_LOG_DEPTH_N:0]   r_count;

  logic [31:0] w_v;
  logic w_wr, w_hit, w_act, w_cmd, w_badWr, w_timeoutHit;
  logic w_flagWr, w_finish, w_logWr, w_typeWr, w_numWr, w_resultWr, w_expectWr;
  logic w_pop, w_push, w_drop, w_full;

  generate
    if (P_SWAP != 0) begin : g_swap
      assign w_v = {iMEMORY_DATA[7:0], iMEMORY_DATA[15:8], iMEMORY_DATA[23:16], iMEMORY_DATA[31:24]};
    end else begin : g_raw
      assign w_v = iMEMORY_DATA;
    end
  endgenerate

  assign w_wr    = iMEMORY_REQ & ~iMEMORY_LOCK & iMEMORY_RW;
  assign w_hit   = (iMEMORY_ADDR[31:5] == P_BASE_ADDR[31:5]);
  assign w_act   = w_wr & w_hit & (iMEMORY_ORDER == 2'b10) & (iMEMORY_ADDR[1:0] == 2'b00);
  assign w_badWr = w_wr & w_hit & (iMEMORY_ORDER != 2'b10);
  // Terminal states freeze every register-file write; only FIFO pops keep working
  assign w_cmd   = w_act & (r_state == ST_RUN);

  assign w_flagWr   = w_cmd & (iMEMORY_ADDR[4:2] == 3'd0);
  assign w_finish   = w_cmd & (iMEMORY_ADDR[4:2] == 3'd1);
  assign w_logWr    = w_cmd & (iMEMORY_ADDR[4:2] == 3'd2);
  assign w_typeWr   = w_cmd & (iMEMORY_ADDR[4:2] == 3'd3);
  assign w_numWr    = w_cmd & (iMEMORY_ADDR[4:2] == 3'd4);
  assign w_resultWr = w_cmd & (iMEMORY_ADDR[4:2] == 3'd5);
  assign w_expectWr = w_cmd & (iMEMORY_ADDR[4:2] == 3'd6);

  assign w_full = (r_count == C_FULL);
  assign w_pop  = iLOG_RD & (r_count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the push
  assign w_push = w_logWr & (~w_full | w_pop);
  assign w_drop = w_logWr & w_full & ~w_pop;

`ifdef MIST1032ISA_FUNC_MAILBOX_TIMEOUT_EN
  logic [31:0] r_toCnt;
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      r_toCnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_toCnt <= r_toCnt + 32'd1;
    end
  end
  assign w_timeoutHit = (r_toCnt == P_TIMEOUT - 32'd1);
`else
  logic w_unusedTimeout;
  assign w_unusedTimeout = ^P_TIMEOUT;
  assign w_timeoutHit    = 1'b0;
`endif

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_finish) begin
          w_stateNext = r_flag ? ST_PASS : ST_FAIL;
        end else if (w_timeoutHit) begin
          w_stateNext = ST_TIMEOUT;
        end
      end
      default: w_stateNext = r_state;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      r_state     <= ST_RUN;
      r_flag      <= 1'b0;
      r_errType   <= '0;
      r_errNum    <= '0;
      r_errResult <= '0;
      r_errExpect <= '0;
      r_failCnt   <= '0;
      r_badAccess <= 1'b0;
      r_logOvf    <= 1'b0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_flagWr) begin
        r_flag <= w_v[0];
        if (!w_v[0] && (r_failCnt != 16'hFFFF)) begin
          r_failCnt <= r_failCnt + 16'd1;
        end
      end
      if (w_typeWr)   r_errType   <= w_v;
      if (w_numWr)    r_errNum    <= w_v;
      if (w_resultWr) r_errResult <= w_v;
      if (w_expectWr) r_errExpect <= w_v;
      if (w_badWr)    r_badAccess <= 1'b1;
      if (w_drop)     r_logOvf    <= 1'b1;
      if (w_push)     r_wrPtr     <= r_wrPtr + C_PTR_ONE;
      if (w_pop)      r_rdPtr     <= r_rdPtr + C_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= w_v;
    end
  end

  assign oSTATE      = r_state;
  assign oDONE       = (r_state != ST_RUN);
  assign oERR_TYPE   = r_errType;
  assign oERR_NUM    = r_errNum;
  assign oERR_RESULT = r_errResult;
  assign oERR_EXPECT = r_errExpect;
  assign oFAIL_CNT   = r_failCnt;
  assign oBAD_ACCESS = r_badAccess;
  assign oLOG_OVF    = r_logOvf;
  assign oLOG_VALID  = (r_count != '0);
  assign oLOG_DATA   = (r_count != '0) ? r_mem[r_rdPtr] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_func_test_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_func_test_mailbox
// Purpose  : Self-checking bench for func_test_mailbox: directed scenarios plus
//            randomized bus traffic against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_func_test_mailbox;

  localparam logic [31:0] BASE = 32'h0002_0000;
  localparam int          DEPTH = 8;
`ifdef MIST1032ISA_FUNC_MAILBOX_TIMEOUT_EN
  localparam logic [31:0] TMO = 32'd100;
  localparam bit          TEN = 1'b1;
`else
  localparam logic [31:0] TMO = 32'd750000;
  localparam bit          TEN = 1'b0;
`endif

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b1;
  logic        iMEMORY_REQ = 1'b0, iMEMORY_LOCK = 1'b0, iMEMORY_RW = 1'b0;
  logic [1:0]  iMEMORY_ORDER = 2'b11;
  logic [31:0] iMEMORY_ADDR = '0, iMEMORY_DATA = '0;
  logic        iLOG_RD = 1'b0;
  logic [1:0]  oSTATE;
  logic        oDONE, oBAD_ACCESS, oLOG_VALID, oLOG_OVF;
  logic [31:0] oERR_TYPE, oERR_NUM, oERR_RESULT, oERR_EXPECT, oLOG_DATA;
  logic [15:0] oFAIL_CNT;

  int nChk = 0;
  int nFail = 0;

  func_test_mailbox #(
    .P_BASE_ADDR(BASE), .P_SWAP(1), .P_LOG_DEPTH(DEPTH), .P_LOG_DEPTH_N(3), .P_TIMEOUT(TMO)
  ) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iMEMORY_REQ(iMEMORY_REQ), .iMEMORY_LOCK(iMEMORY_LOCK), .iMEMORY_ORDER(iMEMORY_ORDER),
    .iMEMORY_RW(iMEMORY_RW), .iMEMORY_ADDR(iMEMORY_ADDR), .iMEMORY_DATA(iMEMORY_DATA),
    .oSTATE(oSTATE), .oDONE(oDONE),
    .oERR_TYPE(oERR_TYPE), .oERR_NUM(oERR_NUM), .oERR_RESULT(oERR_RESULT), .oERR_EXPECT(oERR_EXPECT),
    .oFAIL_CNT(oFAIL_CNT), .oBAD_ACCESS(oBAD_ACCESS),
    .oLOG_VALID(oLOG_VALID), .oLOG_DATA(oLOG_DATA), .iLOG_RD(iLOG_RD), .oLOG_OVF(oLOG_OVF)
  );

  always #5 iCLOCK = ~iCLOCK;

  function automatic logic [31:0] swap(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(3-i) +: 8];
    return r;
  endfunction

  // Reference model: a verdict number, a flag bit, an error array and a word queue
  int          mState;
  int          mRun;
  bit          mFlag, mBad, mOvf;
  logic [31:0] mErr [4];
  int          mFailCnt;
  logic [31:0] mLog [$];

  always @(posedge iCLOCK) begin
    if (!inRESET) begin
      mState = 0; mRun = 0; mFlag = 0; mBad = 0; mOvf = 0; mFailCnt = 0;
      for (int i = 0; i < 4; i++) mErr[i] = '0;
      mLog.delete();
    end else begin
      automatic bit wasRun = (mState == 0);
      automatic logic [31:0] v = swap(iMEMORY_DATA);
      if (iLOG_RD && mLog.size() > 0) void'(mLog.pop_front());
      if (iMEMORY_REQ && !iMEMORY_LOCK && iMEMORY_RW && (iMEMORY_ADDR >> 5) == (BASE >> 5)) begin
        if (iMEMORY_ORDER != 2'b10) mBad = 1;
        else if (iMEMORY_ADDR % 4 == 0 && mState == 0) begin
          case (iMEMORY_ADDR % 32)
            0: begin
              mFlag = v[0];
              if (!v[0] && mFailCnt < 65535) mFailCnt++;
            end
            4: mState = mFlag ? 1 : 2;
            8: if (mLog.size() < DEPTH) mLog.push_back(v); else mOvf = 1;
            12, 16, 20, 24: mErr[(iMEMORY_ADDR % 32) / 4 - 3] = v;
            default: ;
          endcase
        end
      end
      if (wasRun) begin
        mRun++;
        if (TEN && mState == 0 && mRun == int'(TMO)) mState = 3;
      end
    end
  end

  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [1:0] ord,
                     input logic lck, input logic rw, input logic rq, input logic rd);
    @(negedge iCLOCK);
    iMEMORY_ADDR = a; iMEMORY_DATA = d; iMEMORY_ORDER = ord;
    iMEMORY_LOCK = lck; iMEMORY_RW = rw; iMEMORY_REQ = rq; iLOG_RD = rd;
    @(posedge iCLOCK);
    #1;
    iMEMORY_REQ = 1'b0; iLOG_RD = 1'b0; iMEMORY_LOCK = 1'b0;
  endtask

  task automatic wword(input logic [31:0] a, input logic [31:0] d);
    cyc(a, d, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic pop();
    cyc('0, '0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge iCLOCK);
    inRESET = 1'b0;
    @(posedge iCLOCK);
    #1;
    inRESET = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    nChk++;
    if ({oSTATE, oDONE, oBAD_ACCESS, oLOG_VALID, oLOG_OVF, oFAIL_CNT} !== '0 ||
        {oERR_TYPE, oERR_NUM, oERR_RESULT, oERR_EXPECT, oLOG_DATA} !== '0) begin
      nFail++;
      $display("FAIL %s: state=%0d done=%0b bad=%0b valid=%0b ovf=%0b cnt=%0d err=%h/%h/%h/%h log=%h, required all zero",
               tag, oSTATE, oDONE, oBAD_ACCESS, oLOG_VALID, oLOG_OVF, oFAIL_CNT,
               oERR_TYPE, oERR_NUM, oERR_RESULT, oERR_EXPECT, oLOG_DATA);
    end
  endtask

  task automatic test_reset();
    inRESET = 1'b0;
    repeat (2) @(posedge iCLOCK);
    #1;
    inRESET = 1'b1;
    check_all_zero("reset_values");
  endtask

  task automatic test_pass();
    do_reset();
    wword(BASE + 0, 32'h0100_0000);
    nChk++;
    if (oSTATE !== 2'b00) begin nFail++; $display("FAIL pass_pre_state: got %0d want 0", oSTATE); end
    wword(BASE + 4, 32'h0);
    nChk++;
    if (oSTATE !== 2'b01 || oDONE !== 1'b1) begin
      nFail++; $display("FAIL pass_state: got state=%0d done=%0b want 1/1", oSTATE, oDONE);
    end
  endtask

  task automatic test_fail_err();
    do_reset();
    wword(BASE + 32'h0C, 32'h0500_0000);
    wword(BASE + 32'h10, 32'h0700_0000);
    wword(BASE + 32'h14, 32'h1234_5678);
    wword(BASE + 32'h18, 32'hAABB_CCDD);
    wword(BASE + 32'h00, 32'h0);
    wword(BASE + 32'h04, 32'h0);
    nChk++;
    if (oERR_TYPE !== 32'd5 || oERR_NUM !== 32'd7 || oERR_RESULT !== 32'h7856_3412 || oERR_EXPECT !== 32'hDDCC_BBAA) begin
      nFail++; $display("FAIL err_fields: got %h %h %h %h want 5 7 78563412 ddccbbaa",
                        oERR_TYPE, oERR_NUM, oERR_RESULT, oERR_EXPECT);
    end
    nChk++;
    if (oFAIL_CNT !== 16'd1 || oSTATE !== 2'b10 || oDONE !== 1'b1) begin
      nFail++; $display("FAIL fail_verdict: got cnt=%0d state=%0d done=%0b want 1/2/1", oFAIL_CNT, oSTATE, oDONE);
    end
    wword(BASE + 32'h0C, 32'h0900_0000);
    wword(BASE + 32'h00, 32'h0);
    wword(BASE + 32'h08, 32'h1);
    nChk++;
    if (oERR_TYPE !== 32'd5 || oFAIL_CNT !== 16'd1 || oLOG_VALID !== 1'b0 || oSTATE !== 2'b10) begin
      nFail++; $display("FAIL terminal_ignore: got type=%h cnt=%0d valid=%0b state=%0d want 5/1/0/2",
                        oERR_TYPE, oFAIL_CNT, oLOG_VALID, oSTATE);
    end
  endtask

  task automatic test_log_overflow();
    do_reset();
    for (int i = 1; i <= 9; i++) wword(BASE + 8, i);
    nChk++;
    if (oLOG_OVF !== 1'b1 || oLOG_VALID !== 1'b1) begin
      nFail++; $display("FAIL log_ovf: got ovf=%0b valid=%0b want 1/1", oLOG_OVF, oLOG_VALID);
    end
    for (int i = 1; i <= 8; i++) begin
      nChk++;
      if (oLOG_DATA !== swap(i) || oLOG_VALID !== 1'b1) begin
        nFail++; $display("FAIL log_pop%0d: got %h valid=%0b want %h", i, oLOG_DATA, oLOG_VALID, swap(i));
      end
      pop();
    end
    nChk++;
    if (oLOG_VALID !== 1'b0 || oLOG_DATA !== 32'h0) begin
      nFail++; $display("FAIL log_empty: got valid=%0b data=%h want 0/0", oLOG_VALID, oLOG_DATA);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp [$];
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom();
      exp.push_back(swap(d));
      wword(BASE + 8, d);
    end
    d = $urandom();
    cyc(BASE + 8, d, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
    void'(exp.pop_front());
    exp.push_back(swap(d));
    nChk++;
    if (oLOG_OVF !== 1'b0) begin nFail++; $display("FAIL full_pushpop_ovf: got %0b want 0", oLOG_OVF); end
    for (int i = 0; i < DEPTH; i++) begin
      nChk++;
      if (oLOG_DATA !== exp[i] || oLOG_VALID !== 1'b1) begin
        nFail++; $display("FAIL full_pushpop_pop%0d: got %h valid=%0b want %h", i, oLOG_DATA, oLOG_VALID, exp[i]);
      end
      pop();
    end
    nChk++;
    if (oLOG_VALID !== 1'b0) begin nFail++; $display("FAIL full_pushpop_count: got valid=%0b want 0", oLOG_VALID); end
    // Push and pop together on an empty FIFO: only the push happens
    cyc(BASE + 8, 32'h4400_0000, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
    nChk++;
    if (oLOG_VALID !== 1'b1 || oLOG_DATA !== 32'h44) begin
      nFail++; $display("FAIL empty_pushpop: got valid=%0b data=%h want 1/44", oLOG_VALID, oLOG_DATA);
    end
  endtask

  task automatic test_bad_access();
    do_reset();
    cyc(BASE + 4, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    nChk++;
    if (oBAD_ACCESS !== 1'b1 || oSTATE !== 2'b00) begin
      nFail++; $display("FAIL bad_access: got bad=%0b state=%0d want 1/0", oBAD_ACCESS, oSTATE);
    end
    do_reset();
    cyc(BASE + 4, 32'h0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(BASE + 4, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(BASE + 32'h24, 32'h0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(BASE + 32'h1C, 32'h0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(BASE + 32'h06, 32'h0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    nChk++;
    if (oSTATE !== 2'b00 || oBAD_ACCESS !== 1'b0) begin
      nFail++; $display("FAIL ignored_access: got state=%0d bad=%0b want 0/0", oSTATE, oBAD_ACCESS);
    end
  endtask

  task automatic test_midrun_reset();
    do_reset();
    wword(BASE + 32'h0C, 32'hDEAD_BEEF);
    wword(BASE + 32'h18, 32'h1111_2222);
    wword(BASE + 32'h00, 32'h0);
    wword(BASE + 32'h08, 32'h5);
    cyc(BASE + 4, 32'h0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    do_reset();
    check_all_zero("midrun_reset");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  ord;
    logic [2:0]  w;
    for (int chunk = 0; chunk < 12; chunk++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        case ($urandom_range(0, 9))
          0:       a = (chunk % 2 == 0) ? BASE + 32'h20 + 4 * $urandom_range(0, 7) : $urandom();
          1:       a = BASE + $urandom_range(0, 31);
          default: begin
            w = 3'($urandom_range(0, 7));
            if (w == 3'd1 && $urandom_range(0, 5) != 0) w = 3'd2;
            a = BASE + {27'd0, w, 2'b00};
          end
        endcase
        ord = ($urandom_range(0, 5) > 1) ? 2'b10 : 2'($urandom_range(0, 3));
        cyc(a, $urandom(), ord, $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        nChk++;
        if (oSTATE !== 2'(mState) || oDONE !== (mState != 0)) begin
          nFail++; $display("FAIL rnd_state c%0d: got %0d/%0b want %0d", c, oSTATE, oDONE, mState);
        end
        nChk++;
        if (oERR_TYPE !== mErr[0] || oERR_NUM !== mErr[1] || oERR_RESULT !== mErr[2] || oERR_EXPECT !== mErr[3]) begin
          nFail++; $display("FAIL rnd_err c%0d: got %h %h %h %h want %h %h %h %h", c,
                            oERR_TYPE, oERR_NUM, oERR_RESULT, oERR_EXPECT, mErr[0], mErr[1], mErr[2], mErr[3]);
        end
        nChk++;
        if (oFAIL_CNT !== 16'(mFailCnt) || oBAD_ACCESS !== mBad || oLOG_OVF !== mOvf) begin
          nFail++; $display("FAIL rnd_flags c%0d: got cnt=%0d bad=%0b ovf=%0b want %0d/%0b/%0b", c,
                            oFAIL_CNT, oBAD_ACCESS, oLOG_OVF, mFailCnt, mBad, mOvf);
        end
        nChk++;
        if (oLOG_VALID !== (mLog.size() > 0) || oLOG_DATA !== ((mLog.size() > 0) ? mLog[0] : 32'h0)) begin
          nFail++; $display("FAIL rnd_log c%0d: got valid=%0b data=%h want size=%0d", c, oLOG_VALID, oLOG_DATA, mLog.size());
        end
      end
    end
  endtask

`ifdef MIST1032ISA_FUNC_MAILBOX_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    idle(int'(TMO) - 1);
    nChk++;
    if (oSTATE !== 2'b00) begin nFail++; $display("FAIL timeout_early: got %0d want 0", oSTATE); end
    idle(1);
    nChk++;
    if (oSTATE !== 2'b11 || oDONE !== 1'b1) begin
      nFail++; $display("FAIL timeout_state: got %0d/%0b want 3/1", oSTATE, oDONE);
    end
    wword(BASE + 0, 32'h0100_0000);
    wword(BASE + 4, 32'h0);
    nChk++;
    if (oSTATE !== 2'b11) begin nFail++; $display("FAIL timeout_terminal: got %0d want 3", oSTATE); end
    do_reset();
    check_all_zero("timeout_reset");
    // Finish on the very cycle the counter expires beats the timeout
    wword(BASE + 0, 32'h0100_0000);
    idle(int'(TMO) - 2);
    wword(BASE + 4, 32'h0);
    nChk++;
    if (oSTATE !== 2'b01) begin nFail++; $display("FAIL timeout_race: got %0d want 1", oSTATE); end
  endtask
`endif

  initial begin
    test_reset();
    test_pass();
    test_fail_err();
    test_log_overflow();
    test_full_push_pop();
    test_bad_access();
    test_midrun_reset();
    test_random();
`ifdef MIST1032ISA_FUNC_MAILBOX_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
`default_nettype wire
